pipelined_addsub: RTL and testbench

//  Parametrised successor of the single-cycle adder: carry-split pipelined add/subtract unit.

---
 rtl/addsub_pkg.sv | 17 +
 rtl/addsub_stage.sv | 76 +++++++
 rtl/pipelined_addsub.sv | 110 +++++++++++
 tb/tb_pipelined_addsub.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the carry-split pipelined add/subtract unit.
package addsub_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  // Fixed part of a stage payload; the sum-so-far and remaining operand
  // vectors depend on the data width and are sized in addsub_stage.
  typedef struct packed {
    logic carry;
    op_e  op;
  } stage_ctl_t;

  function automatic int unsigned chunk_w(input int unsigned w, input int unsigned s);
    return (s == 0) ? w : (w / s);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage: adds chunk g_index of the operands plus the incoming
// carry and holds sum-so-far, operands, carry and op in an elastic register.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int unsigned g_data_width = 8,
  parameter int unsigned g_stages     = 2,
  parameter int unsigned g_index      = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic                    i_ready,
  input  logic [g_data_width-1:0] i_res,
  input  logic [g_data_width-1:0] i_a,
  input  logic [g_data_width-1:0] i_b,
  input  stage_ctl_t              i_ctl,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [g_data_width-1:0] o_res,
  output logic [g_data_width-1:0] o_a,
  output logic [g_data_width-1:0] o_b,
  output stage_ctl_t              o_ctl
);

  localparam int unsigned CW = chunk_w(g_data_width, g_stages);
  localparam int unsigned LO = g_index * CW;

  logic                    r_valid;
  logic [g_data_width-1:0] r_res;
  logic [g_data_width-1:0] r_a;
  logic [g_data_width-1:0] r_b;
  stage_ctl_t              r_ctl;

  logic [CW:0]             w_sum;
  logic [g_data_width-1:0] w_res;
  logic                    w_unused_res;

  // Chunk adder; its result overwrites this stage's slice of the running sum.
  always_comb begin
    w_sum = {1'b0, i_a[LO +: CW]} + {1'b0, i_b[LO +: CW]} + {{CW{1'b0}}, i_ctl.carry};
    w_res = i_res;
    w_res[LO +: CW] = w_sum[CW-1:0];
  end

  assign w_unused_res = ^i_res[LO +: CW];

  // The register may load when empty or when its current item leaves this cycle.
  assign o_ready = ~r_valid | i_ready;

  // Elastic payload register; holds data, carry and valid while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ctl   <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_res <= w_res;
        r_a   <= i_a;
        r_b   <= i_b;
        r_ctl <= '{carry: w_sum[CW], op: i_ctl.op};
      end
    end
  end

  assign o_valid = r_valid;
  assign o_res   = r_res;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_ctl   = r_ctl;

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-split pipelined add/subtract unit with valid/ready handshake.
// Optional saturating outputs o_sat/o_ovf when ADDSUB_SAT_EN is defined.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned g_data_width = 8,
  parameter int unsigned g_stages     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_sub,
  input  logic [g_data_width-1:0] i_A,
  input  logic [g_data_width-1:0] i_B,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [g_data_width:0]   o_C,
`ifdef ADDSUB_SAT_EN
  output logic [g_data_width-1:0] o_sat,
  output logic                    o_ovf,
`endif
  output logic                    o_busy
);

  localparam int unsigned W = g_data_width;
  localparam int unsigned S = g_stages;

  if ((S < 1) || (S > W) || ((W % ((S < 1) ? 1 : S)) != 0)) begin : g_param_err
    $error("pipelined_addsub: g_data_width must be a multiple of g_stages, 1 <= g_stages <= g_data_width");
  end

  logic [S-1:0] w_valid_vec;
  logic         w_unused_tail;

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic         w_in_valid;
    logic [W-1:0] w_in_res;
    logic [W-1:0] w_in_a;
    logic [W-1:0] w_in_b;
    stage_ctl_t   w_in_ctl;
    logic         w_down_ready;
    logic         w_up_ready;
    logic         w_valid;
    logic [W-1:0] w_res;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    stage_ctl_t   w_ctl;

    // Subtraction is A + ~B + 1: B is inverted once at the head, carry-in is the op bit.
    if (k == 0) begin : g_head
      assign w_in_valid = i_valid;
      assign w_in_res   = '0;
      assign w_in_a     = i_A;
      assign w_in_b     = i_B ^ {W{i_sub}};
      assign w_in_ctl   = '{carry: i_sub, op: (i_sub ? OP_SUB : OP_ADD)};
    end else begin : g_body
      assign w_in_valid = g_stage[k-1].w_valid;
      assign w_in_res   = g_stage[k-1].w_res;
      assign w_in_a     = g_stage[k-1].w_a;
      assign w_in_b     = g_stage[k-1].w_b;
      assign w_in_ctl   = g_stage[k-1].w_ctl;
    end

    if (k == S - 1) begin : g_tail
      assign w_down_ready = i_ready;
    end else begin : g_mid
      assign w_down_ready = g_stage[k+1].w_up_ready;
    end

    addsub_stage #(
      .g_data_width (W),
      .g_stages     (S),
      .g_index      (k)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (w_in_valid),
      .i_ready (w_down_ready),
      .i_res   (w_in_res),
      .i_a     (w_in_a),
      .i_b     (w_in_b),
      .i_ctl   (w_in_ctl),
      .o_ready (w_up_ready),
      .o_valid (w_valid),
      .o_res   (w_res),
      .o_a     (w_a),
      .o_b     (w_b),
      .o_ctl   (w_ctl)
    );

    assign w_valid_vec[k] = w_valid;
  end

  assign w_unused_tail = ^{g_stage[S-1].w_a, g_stage[S-1].w_b};

  assign o_ready = g_stage[0].w_up_ready;
  assign o_valid = g_stage[S-1].w_valid;
  assign o_busy  = |w_valid_vec;
  // For subtraction the final carry is the inverted borrow.
  assign o_C     = {g_stage[S-1].w_ctl.carry ^ (g_stage[S-1].w_ctl.op == OP_SUB),
                    g_stage[S-1].w_res};

`ifdef ADDSUB_SAT_EN
  assign o_ovf = o_C[W];
  assign o_sat = (!o_C[W]) ? o_C[W-1:0] :
                 ((g_stage[S-1].w_ctl.op == OP_SUB) ? {W{1'b0}} : {W{1'b1}});
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed vectors, streaming,
// back-pressure, mid-flight reset and randomised traffic.
module tb_pipelined_addsub;

`ifdef ADDSUB_SAT_EN
  localparam int W = 16;
  localparam int S = 4;
`else
  localparam int W = 8;
  localparam int S = 2;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_sub = 1'b0;
  logic         i_ready = 1'b1;
  logic [W-1:0] i_A = '0;
  logic [W-1:0] i_B = '0;
  logic         o_ready;
  logic         o_valid;
  logic         o_busy;
  logic [W:0]   o_C;
`ifdef ADDSUB_SAT_EN
  logic [W-1:0] o_sat;
  logic         o_ovf;
`endif

  pipelined_addsub #(.g_data_width(W), .g_stages(S)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_sub   (i_sub),
    .i_A     (i_A),
    .i_B     (i_B),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_C     (o_C),
`ifdef ADDSUB_SAT_EN
    .o_sat   (o_sat),
    .o_ovf   (o_ovf),
`endif
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_out    = 0;
  logic [W+1:0] sb_q[$];
  logic [W+1:0] sb_e;
  logic         hold_pending = 1'b0;
  logic [W:0]   held_c;
  logic         any_stall;
  logic         st;
  logic         rnd_done;
  int           n0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    if (sub) return {(a < b), d};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Monitor: pops expectations on delivery, checks o_C stability while stalled.
  always @(negedge i_clk) begin
    if (i_rst) begin
      hold_pending = 1'b0;
    end else if (o_valid) begin
      if (hold_pending) check_eq("hold_stable", 64'(o_C), 64'(held_c));
      if (!i_ready) begin
        held_c = o_C;
        hold_pending = 1'b1;
      end else begin
        hold_pending = 1'b0;
        n_out++;
        if (sb_q.size() == 0) begin
          check_eq("spurious_result", 64'(o_C), 64'(0) - 64'(1));
        end else begin
          sb_e = sb_q.pop_front();
          check_eq("result", 64'(o_C), 64'(sb_e[W:0]));
`ifdef ADDSUB_SAT_EN
          check_eq("ovf", 64'(o_ovf), 64'(sb_e[W]));
          check_eq("sat", 64'(o_sat), (!sb_e[W]) ? 64'(sb_e[W-1:0]) :
                   (sb_e[W+1] ? 64'(0) : 64'({W{1'b1}})));
`endif
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic send(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b, output logic stalled);
    i_valid = 1'b1;
    i_sub   = sub;
    i_A     = a;
    i_B     = b;
    stalled = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge i_clk);
      if (o_ready) begin
        sb_q.push_back({sub, model(sub, a, b)});
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_A     = W'($urandom);
        i_B     = W'($urandom);
        i_sub   = 1'($urandom);
        return;
      end
      stalled = 1'b1;
      @(posedge i_clk);
      #1;
    end
    check_eq("accept_timeout", 64'(0), 64'(1));
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 300; t++) begin
      if (sb_q.size() == 0) break;
      @(posedge i_clk);
      #1;
    end
    check_eq(tag, 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_valid", 64'(o_valid), 64'(0));
    check_eq("rst_busy", 64'(o_busy), 64'(0));
    check_eq("rst_c", 64'(o_C), 64'(0));
    i_rst = 1'b0;
    #1;
    check_eq("rst_ready", 64'(o_ready), 64'(1));
    @(posedge i_clk);
    #1;

    // Carry across the chunk boundary, with exact latency
    send(1'b0, {W{1'b1}}, W'(1), st);
    for (int k = 0; k < S - 1; k++) begin
      check_eq("lat_not_yet", 64'(o_valid), 64'(0));
      @(posedge i_clk);
      #1;
    end
    check_eq("lat_valid", 64'(o_valid), 64'(1));
    check_eq("lat_c", 64'(o_C), 64'(1) << W);
    send(1'b1, W'(5), W'(7), st);
    send(1'b1, W'(7), W'(5), st);
`ifdef ADDSUB_SAT_EN
    send(1'b0, 16'hFFF0, 16'h0020, st);
    send(1'b1, 16'h0010, 16'h0020, st);
`endif
    wait_drain("directed_drain");

    // 16 back-to-back items at full throughput
    n0 = n_out;
    any_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(1'(i % 3 == 0), W'($urandom), W'($urandom), st);
      any_stall |= st;
    end
    repeat (S) @(posedge i_clk);
    #1;
    check_eq("stream_ready_low", 64'(any_stall), 64'(0));
    check_eq("stream_count", 64'(n_out - n0), 64'(16));

    // Back-pressure for 5 cycles while streaming
    n0 = n_out;
    any_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(1'(i % 2), W'($urandom), W'($urandom), st);
          any_stall |= st;
        end
      end
      begin
        repeat (3) @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    wait_drain("stall_drain");
    check_eq("stall_ready_dropped", 64'(any_stall), 64'(1));
    check_eq("stall_count", 64'(n_out - n0), 64'(10));

    // Reset with two items in flight
    send(1'b0, W'(3), W'(4), st);
    send(1'b1, W'(9), W'(2), st);
    i_rst = 1'b1;
    #1;
    check_eq("flush_valid", 64'(o_valid), 64'(0));
    check_eq("flush_busy", 64'(o_busy), 64'(0));
    sb_q.delete();
    n0 = n_out;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (S + 4) @(posedge i_clk);
    #1;
    check_eq("flush_no_stale", 64'(n_out - n0), 64'(0));
    check_eq("flush_ready", 64'(o_ready), 64'(1));

    // Random traffic with random back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(1'($urandom), W'($urandom), W'($urandom), st);
        rnd_done = 1'b1;
      end
      begin
        for (int t = 0; t < 500 && !rnd_done; t++) begin
          @(posedge i_clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    wait_drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
